// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared definitions for the multicycle memory access
//               sequencer: access op codes, FSM state encoding, lane masks
//               and small decode helpers.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_pkg;

   // Access op codes
   localparam logic [2:0] OP_LW = 3'b000;
   localparam logic [2:0] OP_LH = 3'b001;
   localparam logic [2:0] OP_LB = 3'b010;
   localparam logic [2:0] OP_SW = 3'b100;
   localparam logic [2:0] OP_SH = 3'b101;
   localparam logic [2:0] OP_SB = 3'b110;

   // Lane widths and masks (lane 0 position, shifted into place by the user)
   localparam int          BYTE_W    = 8;
   localparam int          HALF_W    = 16;
   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   // Unknown codes collapse to LW so the rest of the datapath only ever
   // sees the six legal encodings.
   function automatic logic [2:0] norm_op(input logic [2:0] op);
      case (op)
         OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB: norm_op = op;
         default:                                  norm_op = OP_LW;
      endcase
   endfunction

   // Alignment test on a normalised op.
   function automatic logic addr_ok(input logic [2:0] op, input logic [1:0] a);
      case (op)
         OP_LW, OP_SW: addr_ok = (a == 2'b00);
         OP_LH, OP_SH: addr_ok = (a[0] == 1'b0);
         default:      addr_ok = 1'b1;
      endcase
   endfunction

   // Bit 2 of a normalised op distinguishes stores from loads.
   function automatic logic is_store(input logic [2:0] op);
      is_store = op[2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_unit
// Description : Combinational lane steering for little-endian sub-word
//               accesses against a 32-bit word.
//   op_i      : normalised access op
//   addr_lo_i : byte offset within the word
//   rdata_i   : word read from memory
//   wdata_i   : store data (low lanes used for SB/SH)
//   load_o    : addressed lane, zero-extended
//   merge_o   : rdata_i with the addressed lane replaced by store data
// Revision    : 1.0  initial release
// ============================================================================
module byte_lane_unit
   import mem_access_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [4:0]  w_byte_sh;
   logic [4:0]  w_half_sh;
   logic [31:0] w_byte_word;
   logic [31:0] w_half_word;
   logic [31:0] w_byte_mask;
   logic [31:0] w_half_mask;

   // Bit offsets of the addressed byte / halfword
   assign w_byte_sh   = {addr_lo_i, 3'b000};
   assign w_half_sh   = {addr_lo_i[1], 4'b0000};

   // Addressed lane moved down to bit 0
   assign w_byte_word = rdata_i >> w_byte_sh;
   assign w_half_word = rdata_i >> w_half_sh;

   assign w_byte_mask = BYTE_MASK << w_byte_sh;
   assign w_half_mask = HALF_MASK << w_half_sh;

   always_comb begin
      load_o  = rdata_i;
      merge_o = wdata_i;
      case (op_i)
         OP_LB: load_o = w_byte_word & BYTE_MASK;
         OP_LH: load_o = w_half_word & HALF_MASK;
         OP_SB: merge_o = (rdata_i & ~w_byte_mask)
                        | (((wdata_i & BYTE_MASK) << w_byte_sh) & w_byte_mask);
         OP_SH: merge_o = (rdata_i & ~w_half_mask)
                        | (((wdata_i & HALF_MASK) << w_half_sh) & w_half_mask);
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Multicycle memory access sequencer. Captures a request on
//               start, then runs word/halfword/byte loads and stores against
//               a word-wide memory with one-cycle read latency. Sub-word
//               stores are read-modify-write.
//   clk, reset          : clock, synchronous active-high reset
//   start, op, addr,
//   wdata               : request strobe, access type, byte address, data
//   mem_rdata           : memory read word (one cycle after mem_addr)
//   mem_addr, mem_wdata,
//   mem_wr              : memory address, write word, write enable
//   rdata               : zero-extended load result (held)
//   busy, done,
//   align_err           : status
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        align_err
);

   state_t      state_q,  state_d;
   logic [31:0] addr_q,   addr_d;
   logic [2:0]  op_q,     op_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [31:0] merge_q,  merge_d;
   logic [31:0] rdata_q,  rdata_d;

   logic [2:0]  w_op_in;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   assign w_op_in = norm_op(op);

   byte_lane_unit u_lane (
      .op_i      (op_q),
      .addr_lo_i (addr_q[1:0]),
      .rdata_i   (mem_rdata),
      .wdata_i   (wdata_q),
      .load_o    (w_load),
      .merge_o   (w_merge)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         op_q    <= OP_LW;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      op_d    = op_q;
      wdata_d = wdata_q;
      merge_d = merge_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = addr;
               op_d    = w_op_in;
               wdata_d = wdata;
               // Misaligned requests never touch memory or rdata.
               if (!addr_ok(w_op_in, addr[1:0]))
                  state_d = ST_ERR;
               else if (w_op_in == OP_SW)
                  state_d = ST_WRITE;
               else
                  state_d = ST_READ;
            end
         end
         ST_READ:  state_d = ST_WAIT;
         ST_WAIT: begin
            // mem_rdata is valid here for the address issued in READ.
            if (is_store(op_q)) begin
               merge_d = w_merge;
               state_d = ST_WRITE;
            end else begin
               rdata_d = w_load;
               state_d = ST_DONE;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr    = 1'b0;
      if (state_q != ST_IDLE)
         mem_addr = {addr_q[31:2], 2'b00};
      if (state_q == ST_WRITE) begin
         mem_wr    = 1'b1;
         mem_wdata = (op_q == OP_SW) ? wdata_q : merge_q;
      end
   end

   assign rdata     = rdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign align_err = (state_q == ST_ERR);

endmodule
`default_nettype wire
